// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: data-memory request/response bus between the CPU controller and the memory responder
// master (controller) drives mem_read, mem_write, addr, wdata; slave (responder) drives rdata, ready, busy, err
interface data_mem_responder_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;
   modport master (output mem_read, mem_write, addr, wdata, input rdata, ready, busy, err);
   modport slave (input mem_read, mem_write, addr, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-array memory responder with programmable wait states and a one-cycle ready pulse
// clk: rising-edge clock; reset: asynchronous active-high reset
// bus (slave): mem_read/mem_write/addr/wdata in; rdata (registered load data), ready, busy, err out
module data_mem_responder #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic                  clk,
   input logic                  reset,
   data_mem_responder_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              accept, commit, in_range;
   logic [DATA_W-1:0] mem [DEPTH];
   // addr_d/wdata_d/we_d are the live request on the accepting edge, else the latched one; with
   // zero wait states the commit happens on that same edge, so it must use the live values.
   always_comb begin
      accept   = state_q == S_IDLE && (bus.mem_read ^ bus.mem_write);
      addr_d   = accept ? bus.addr : addr_q;
      wdata_d  = accept ? bus.wdata : wdata_q;
      we_d     = accept ? bus.mem_write : we_q;
      in_range = {1'b0, addr_d} < DEPTH_L;
      state_d  = state_q;
      cnt_d    = cnt_q;
      if (accept) begin
         state_d = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
         cnt_d   = CNT_INIT;
      end else if (state_q == S_WAIT) begin
         state_d = cnt_q == 4'd0 ? S_RESP : S_WAIT;
         cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end else if (state_q == S_RESP) begin
         state_d = S_IDLE;
      end
      commit  = state_d == S_RESP && state_q != S_RESP;
      rdata_d = commit && !we_d ? (in_range ? mem[addr_d[IW-1:0]] : '0) : rdata_q;
      err_d   = state_q == S_IDLE && bus.mem_read && bus.mem_write;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk) begin
      if (commit && we_d && in_range) mem[addr_d[IW-1:0]] <= wdata_d;
   end
   // in RESP nothing is accepted, so in_range reflects the latched address
   assign bus.rdata = rdata_q;
   assign bus.ready = state_q == S_RESP;
   assign bus.busy  = state_q != S_IDLE;
   assign bus.err   = err_q | (state_q == S_RESP && !in_range);
endmodule
